fp_add_arbiter: RTL and testbench
=================================

# fp_add_arbiter

Sequential front end that shares one combinational single-precision adder between `NUM_REQ` requesters. Round-robin arbitration selects one request, registers its operands and rounding mode, evaluates the adder, and returns the registered result tagged with the requester index. The result is held until the consumer accepts it. The block sits between the issue logic of the FPU lanes and the `fp_adder` datapath instance it owns.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag.

Ports (the clock is `clk`; reset is `rst_n`, asynchronous and active-low):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in `NUM_REQ`: request pending, one bit per requester.
- `req_ready` out `NUM_REQ`: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_a` in `NUM_REQ`x32: operand A per requester, IEEE-754 single.
- `req_b` in `NUM_REQ`x32: operand B per requester.
- `req_rmode` in `NUM_REQ`x3: rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM).
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts the result.
- `resp_id` out `ID_W`: index of the requester that owns the result.
- `resp_result` out 32: sum.
- `resp_overflow` out 1: adder overflow flag.
- `resp_underflow` out 1: adder underflow flag.
- `resp_bad_rm` out 1: the request carried `rmode` 5..7 and was executed as RNE.

## Operation
- FSM states are IDLE, EXEC and RESP. The reset state is IDLE.
- IDLE:
  - If any `req_valid` is set, the arbiter raises exactly one `req_ready` bit, for the winner.
  - On that edge the block captures `req_a`, `req_b`, `rmode`, the requester id and the bad-rm flag, then moves to EXEC.
  - If no `req_valid` is set, the block stays in IDLE.
- EXEC:
  - The adder is evaluated from the operand register.
  - `resp_result` and the flags are captured, and the block moves to RESP.
  - `req_ready` is all zero in EXEC.
- RESP:
  - `resp_valid` is 1, and all resp outputs stay stable until `resp_ready`.
  - If `resp_ready` is 1 and any `req_valid` is set, a new grant is issued in the same cycle and the block moves to EXEC. This is the back-to-back path.
  - If `resp_ready` is 1 and no request is pending, the block moves to IDLE.
  - If `resp_ready` is 0, the block stays in RESP and `req_ready` is all zero.
- Round-robin:
  - The pointer `last_grant` is updated only on an accepted grant.
  - Priority order is `last_grant+1 .. last_grant`, mod `NUM_REQ`.
  - The reset value of `last_grant` is `NUM_REQ-1`, so requester 0 wins first.
  - No requester waits more than `NUM_REQ-1` grants while its `req_valid` is held.
- Rounding mode:
  - `rmode` > 4 is replaced by 0 before the operand register.
  - `resp_bad_rm` = 1 for that transaction.
- `req_valid` may drop without a transfer; the arbiter re-evaluates every cycle.

## Timing
- Reset values of all outputs are 0. This covers `req_ready`, `resp_valid`, `resp_id`, `resp_result`, `resp_overflow`, `resp_underflow` and `resp_bad_rm`. The FSM resets to IDLE and `last_grant` to `NUM_REQ-1`.
- Latency: a grant in cycle T gives `resp_valid` = 1 from cycle T+2.
- Throughput: one operation per 2 cycles with `resp_ready` held at 1; one per 3 cycles when the block passes through IDLE.
- `req_ready` is combinational from `req_valid`, the FSM state and `resp_ready`. There is no combinational path from `req_*` data to the resp outputs.
- Reset asserted mid-operation clears everything immediately:
  - the in-flight result is discarded;
  - `resp_valid` drops asynchronously.
- A request presented in the same cycle that `rst_n` deasserts is not granted before the first rising edge with `rst_n` high.

## Structure
- Shared package `fp_ctrl_pkg` holds:
  - the `rmode_e` enum (RNE, RTZ, RDN, RUP, RMM);
  - the `arb_state_e` enum (IDLE, EXEC, RESP);
  - the `FP_W` = 32 constant.
- Sub-module `rr_arbiter`:
  - parameterised by `NUM_REQ`;
  - inputs: request vector and an `advance` strobe;
  - outputs: one-hot grant and the encoded index;
  - owns `last_grant`.
- One `fp_adder` instance is driven from the operand register.
- An output register holds result, flags, id and `bad_rm`.

## Test plan
- Single add: requester 2 sends A=0x3F800000, B=0x40000000, rmode=0.
  - `req_ready` = 0b0100 in the grant cycle.
  - Two cycles later: `resp_valid`=1, `resp_id`=2, `resp_result`=0x40400000, flags 0.
- Zero add: A=B=0x00000000, rmode=1 → `resp_result`=0x00000000, overflow=0, underflow=0.
- Contention: all 4 requesters hold `req_valid` and `resp_ready`=1.
  - Grants go to 0,1,2,3,0 on every 2nd cycle.
  - `resp_id` sequence is 0,1,2,3.
- Backpressure: hold `resp_ready`=0 for 5 cycles while in RESP.
  - `resp_*` stays constant and `req_ready`=0.
  - Raising `resp_ready` with a pending request grants in that same cycle.
- Bad mode: A=0x7F7FFFFF, B=0x7F7FFFFF, rmode=6.
  - `resp_bad_rm`=1 and `resp_overflow`=1.
  - The result is the RNE result, +inf (0x7F800000).
- Reset mid-op: assert `rst_n`=0 during EXEC.
  - All outputs read 0 immediately.
  - After release, requester 0 wins first.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the FP adder front end and its datapath.
package fp_ctrl_pkg;
  localparam int FP_W = 32;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rmode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder with five rounding modes.
module fp_adder
  import fp_ctrl_pkg::*;
(
  input  logic [FP_W-1:0] i_a,
  input  logic [FP_W-1:0] i_b,
  input  rmode_e          i_rm,
  output logic [FP_W-1:0] o_res,
  output logic            o_ovf,
  output logic            o_unf
);
  logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_d;
  logic [23:0] w_ma, w_mb, w_mx, w_my;
  logic        w_swap, w_sx, w_sy, w_st, w_g, w_rs, w_inc, w_huge;
  logic [26:0] w_sh, w_al, w_nm;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [9:0]  w_e, w_shl;
  logic [24:0] w_rnd;

  always_comb begin
    w_ea   = i_a[30:23];
    w_eb   = i_b[30:23];
    w_ma   = {|w_ea, i_a[22:0]};
    w_mb   = {|w_eb, i_b[22:0]};
    w_swap = {w_eb, i_b[22:0]} > {w_ea, i_a[22:0]};
    w_sx   = w_swap ? i_b[31] : i_a[31];
    w_sy   = w_swap ? i_a[31] : i_b[31];
    // Denormals share the exponent of the smallest normal.
    w_ex   = w_swap ? ((w_eb == 8'd0) ? 8'd1 : w_eb) : ((w_ea == 8'd0) ? 8'd1 : w_ea);
    w_ey   = w_swap ? ((w_ea == 8'd0) ? 8'd1 : w_ea) : ((w_eb == 8'd0) ? 8'd1 : w_eb);
    w_mx   = w_swap ? w_mb : w_ma;
    w_my   = w_swap ? w_ma : w_mb;
    w_d    = w_ex - w_ey;
    w_sh   = {w_my, 3'b000};
    if (w_d >= 8'd27) begin
      w_al = '0;
      w_st = |w_my;
    end else begin
      w_al = w_sh >> w_d;
      w_st = |(w_sh & ((27'd1 << w_d) - 27'd1));
    end
    w_al[0] = w_al[0] | w_st;
    w_sum = (w_sx == w_sy) ? ({1'b0, w_mx, 3'b000} + {1'b0, w_al})
                           : ({1'b0, w_mx, 3'b000} - {1'b0, w_al});

    w_e   = {2'b00, w_ex};
    w_lz  = 5'd27;
    w_shl = '0;
    w_nm  = '0;
    for (int i = 0; i < 27; i++) if (w_sum[i]) w_lz = 5'(26 - i);
    if (w_sum[27]) begin
      w_nm = w_sum[27:1] | {26'b0, w_sum[0]};
      w_e  = w_e + 10'd1;
    end else begin
      // Left shift stops at the denormal boundary so e never drops below 1.
      w_shl = ({5'b0, w_lz} < (w_e - 10'd1)) ? {5'b0, w_lz} : (w_e - 10'd1);
      w_nm  = w_sum[26:0] << w_shl;
      w_e   = w_e - w_shl;
    end

    w_g  = w_nm[2];
    w_rs = |w_nm[1:0];
    case (i_rm)
      RTZ:     w_inc = 1'b0;
      RDN:     w_inc = w_sx & (w_g | w_rs);
      RUP:     w_inc = ~w_sx & (w_g | w_rs);
      RMM:     w_inc = w_g;
      default: w_inc = w_g & (w_rs | w_nm[3]);
    endcase
    w_rnd = {1'b0, w_nm[26:3]} + {24'b0, w_inc};
    if (w_rnd[24]) begin
      w_rnd = w_rnd >> 1;
      w_e   = w_e + 10'd1;
    end

    o_res  = {w_sx, (w_rnd[23] ? w_e[7:0] : 8'd0), w_rnd[22:0]};
    o_ovf  = 1'b0;
    o_unf  = ~w_rnd[23] & (w_g | w_rs);
    w_huge = (i_rm == RTZ) | ((i_rm == RDN) & ~w_sx) | ((i_rm == RUP) & w_sx);
    if (w_e >= 10'd255) begin
      o_ovf = 1'b1;
      o_res = w_huge ? {w_sx, 8'hFE, 23'h7FFFFF} : {w_sx, 8'hFF, 23'h0};
    end
    if (w_sum == 28'd0) begin
      o_res = {((w_sx == w_sy) ? w_sx : (i_rm == RDN)), 31'b0};
      o_unf = 1'b0;
    end
    if (((w_ea == 8'hFF) && (|i_a[22:0])) || ((w_eb == 8'hFF) && (|i_b[22:0])) ||
        ((w_ea == 8'hFF) && (w_eb == 8'hFF) && (i_a[31] != i_b[31]))) begin
      o_res = QNAN;
      o_ovf = 1'b0;
      o_unf = 1'b0;
    end else if ((w_ea == 8'hFF) || (w_eb == 8'hFF)) begin
      o_res = (w_ea == 8'hFF) ? i_a : i_b;
      o_ovf = 1'b0;
      o_unf = 1'b0;
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the pointer moves to the winner only on an accepted grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);
  logic [ID_W-1:0] r_last_grant;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  // Scan last_grant+1 .. last_grant (mod NUM_REQ); first pending requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last_grant} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      w_cand = w_sum[ID_W-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_last_grant <= ID_W'(NUM_REQ - 1);
    else if (i_advance) r_last_grant <= o_idx;
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one combinational fp_adder among NUM_REQ requesters: grant, execute, hold result.
module fp_add_arbiter
  import fp_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][FP_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][FP_W-1:0]  req_b,
  input  logic [NUM_REQ-1:0][2:0]       req_rmode,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [FP_W-1:0]               resp_result,
  output logic                          resp_overflow,
  output logic                          resp_underflow,
  output logic                          resp_bad_rm
);
  arb_state_e        r_state, w_next;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_advance, w_open;
  logic [2:0]        w_rm_in;
  logic              w_bad;
  logic [FP_W-1:0]   r_a, r_b, w_sum;
  rmode_e            r_rm;
  logic [ID_W-1:0]   r_id;
  logic              r_bad, w_ovf, w_unf;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (req_valid),
    .i_advance(w_advance),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req_valid) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (resp_ready) w_next = (|req_valid) ? EXEC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant window: IDLE, or RESP while the consumer drains the current result.
  always_comb begin
    w_open     = (r_state == IDLE) || ((r_state == RESP) && resp_ready);
    req_ready  = (w_open && rst_n) ? w_grant : '0;
    w_advance  = |req_ready;
    resp_valid = (r_state == RESP);
  end

  assign w_rm_in = req_rmode[w_idx];
  assign w_bad   = (w_rm_in > 3'd4);

  // Operand register, loaded on an accepted grant
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_a   <= req_a[w_idx];
      r_b   <= req_b[w_idx];
      r_rm  <= w_bad ? RNE : rmode_e'(w_rm_in);
      r_id  <= w_idx;
      r_bad <= w_bad;
    end
  end

  fp_adder u_add (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_rm (r_rm),
    .o_res(w_sum),
    .o_ovf(w_ovf),
    .o_unf(w_unf)
  );

  // Output register, loaded at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id        <= '0;
      resp_result    <= '0;
      resp_overflow  <= 1'b0;
      resp_underflow <= 1'b0;
      resp_bad_rm    <= 1'b0;
    end else if (r_state == EXEC) begin
      resp_id        <= r_id;
      resp_result    <= w_sum;
      resp_overflow  <= w_ovf;
      resp_underflow <= w_unf;
      resp_bad_rm    <= r_bad;
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: single ops, rounding cases, backpressure, reset, contention.
module tb_fp_add_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0][31:0] req_a = '0;
  logic [N-1:0][31:0] req_b = '0;
  logic [N-1:0][2:0] req_rmode = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [1:0]        resp_id;
  logic [31:0]       resp_result;
  logic              resp_overflow, resp_underflow, resp_bad_rm;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_rmode     (req_rmode),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_result   (resp_result),
    .resp_overflow (resp_overflow),
    .resp_underflow(resp_underflow),
    .resp_bad_rm   (resp_bad_rm)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full single transaction from IDLE: grant, EXEC, RESP, accept.
  task automatic run_one(input string nm, input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, input logic [31:0] er, input logic eo,
                         input logic eu, input logic eb);
    req_a[id]     = a;
    req_b[id]     = b;
    req_rmode[id] = rm;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    #1 check_val({nm, "_grant"}, 32'(req_ready), 32'(1 << id));
    step();
    req_valid = '0;
    #1;
    check_val({nm, "_exec_rdy"}, 32'(req_ready), 32'd0);
    check_val({nm, "_exec_vld"}, 32'(resp_valid), 32'd0);
    step();
    check_val({nm, "_vld"}, 32'(resp_valid), 32'd1);
    check_val({nm, "_id"},  32'(resp_id), 32'(id));
    check_val({nm, "_res"}, resp_result, er);
    check_val({nm, "_ovf"}, 32'(resp_overflow), 32'(eo));
    check_val({nm, "_unf"}, 32'(resp_underflow), 32'(eu));
    check_val({nm, "_bad"}, 32'(resp_bad_rm), 32'(eb));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_val({nm, "_idle"}, 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] cont_exp [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] cont_b   [4] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000};

  initial begin
    #12;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_vld",   32'(resp_valid), 32'd0);
    check_val("rst_id",    32'(resp_id), 32'd0);
    check_val("rst_res",   resp_result, 32'd0);
    check_val("rst_flags", {29'd0, resp_overflow, resp_underflow, resp_bad_rm}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("add",    2, 32'h3F800000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0, 1'b0);
    run_one("zero",   1, 32'h00000000, 32'h00000000, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b0);
    run_one("badrm",  3, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'd6, 32'h7F800000, 1'b1, 1'b0, 1'b1);
    run_one("ovf_rtz",0, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b0);
    run_one("cancel", 1, 32'h3F800000, 32'hBF800000, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0);
    run_one("can_rdn",2, 32'h3F800000, 32'hBF800000, 3'd2, 32'h80000000, 1'b0, 1'b0, 1'b0);
    run_one("tie_rne",3, 32'h3F800000, 32'h33800000, 3'd0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    run_one("tie_rup",0, 32'h3F800000, 32'h33800000, 3'd3, 32'h3F800001, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held while resp_ready is low, then same-cycle regrant.
    req_a[1] = 32'h40000000; req_b[1] = 32'h40000000; req_rmode[1] = 3'd0;
    req_a[0] = 32'h3F800000; req_b[0] = 32'h00000000; req_rmode[0] = 3'd0;
    req_valid = 4'b0010;
    #1 check_val("bp_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_val("bp_vld",   32'(resp_valid), 32'd1);
      check_val("bp_id",    32'(resp_id), 32'd1);
      check_val("bp_res",   resp_result, 32'h40800000);
      check_val("bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    #1 check_val("bp_regrant", 32'(req_ready), 32'h1);
    step();
    req_valid  = '0;
    resp_ready = 1'b0;
    #1 check_val("bp_exec_vld", 32'(resp_valid), 32'd0);
    step();
    check_val("bp2_id",  32'(resp_id), 32'd0);
    check_val("bp2_res", resp_result, 32'h3F800000);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Reset asserted during EXEC clears every output at once.
    req_a[2] = 32'h3F800000; req_b[2] = 32'h40000000; req_rmode[2] = 3'd0;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_vld",   32'(resp_valid), 32'd0);
    check_val("mid_rst_res",   resp_result, 32'd0);
    check_val("mid_rst_id",    32'(resp_id), 32'd0);
    check_val("mid_rst_flags", {29'd0, resp_overflow, resp_underflow, resp_bad_rm}, 32'd0);
    for (int i = 0; i < N; i++) begin
      req_a[i] = 32'h3F800000; req_b[i] = cont_b[i]; req_rmode[i] = 3'd0;
    end
    req_valid = 4'b1111;
    #1 check_val("in_rst_ready", 32'(req_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Contention with resp_ready held high: grants 0,1,2,3 then wrap to 0.
    resp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      #1 check_val("cont_grant", 32'(req_ready), 32'(1 << k));
      if (k > 0) begin
        check_val("cont_id",  32'(resp_id), 32'(k - 1));
        check_val("cont_res", resp_result, cont_exp[k-1]);
      end
      step();
      #1 check_val("cont_exec", 32'(req_ready), 32'd0);
      step();
    end
    #1;
    check_val("cont_wrap", 32'(req_ready), 32'h1);
    check_val("cont_id",   32'(resp_id), 32'd3);
    check_val("cont_res",  resp_result, cont_exp[3]);
    req_valid = '0;
    step();
    resp_ready = 1'b0;
    check_val("end_idle", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
